// File: rtl/seg_display_mux.sv
// Four-digit multiplexed seven-segment driver with PWM brightness gating.
// Optional `SEG_LEADING_BLANK_EN: blanks the leftmost digit when the hours tens value is zero.
module seg_display_mux #(
    parameter int REFRESH_DIV = 100000,
    parameter int PWM_BITS    = 8
) (
    input  logic                CLK100MHZ,
    input  logic                Reset,
    input  logic [3:0]          hours2,
    input  logic [3:0]          hours1,
    input  logic [3:0]          minutes2,
    input  logic [3:0]          minutes1,
    input  logic [PWM_BITS-1:0] brightness,
    output logic [3:0]          SegmentDrivers,
    output logic [7:0]          SevenSegment,
    output logic                test
);

    localparam int RC_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [RC_W-1:0] RC_MAX = RC_W'(REFRESH_DIV - 1);

    logic [RC_W-1:0]     rc, rc_nxt;
    logic [1:0]          idx, idx_nxt;
    logic [PWM_BITS-1:0] pc;
    logic [3:0]          digit_q, digit_nxt;
    logic                load_q;
    logic                pwm_on;
    logic [3:0]          anode_nxt;
    logic [7:0]          cathode_nxt;

    function automatic logic [7:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 8'hC0;
            4'd1:    decode = 8'hF9;
            4'd2:    decode = 8'hA4;
            4'd3:    decode = 8'hB0;
            4'd4:    decode = 8'h99;
            4'd5:    decode = 8'h92;
            4'd6:    decode = 8'h82;
            4'd7:    decode = 8'hF8;
            4'd8:    decode = 8'h80;
            4'd9:    decode = 8'h90;
            default: decode = 8'hBF;
        endcase
    endfunction

    function automatic logic [3:0] bcd_for(input logic [1:0] i, input logic [3:0] h2,
                                           input logic [3:0] h1, input logic [3:0] m2,
                                           input logic [3:0] m1);
        case (i)
            2'd0:    bcd_for = m1;
            2'd1:    bcd_for = m2;
            2'd2:    bcd_for = h1;
            default: bcd_for = h2;
        endcase
    endfunction

    always_comb begin
        rc_nxt      = rc + 1'b1;
        idx_nxt     = idx;
        digit_nxt   = digit_q;
        pwm_on      = (pc < brightness);
        anode_nxt   = 4'hF;
        cathode_nxt = decode(digit_q);

        if (rc == RC_MAX) begin
            rc_nxt    = '0;
            idx_nxt   = idx + 2'd1;
            digit_nxt = bcd_for(idx + 2'd1, hours2, hours1, minutes2, minutes1);
        end else if (load_q) begin
            // First slot after reset: pick up minutes1 during the guard cycle.
            digit_nxt = minutes1;
        end

        if (pwm_on && (rc != '0))
            anode_nxt = ~(4'b0001 << idx);

`ifdef SEG_LEADING_BLANK_EN
        if ((idx == 2'd3) && (digit_q == 4'd0))
            cathode_nxt = 8'hFF;
`endif
    end

    always_ff @(posedge CLK100MHZ) begin
        if (Reset) begin
            rc             <= '0;
            idx            <= 2'd0;
            pc             <= '0;
            digit_q        <= 4'd0;
            load_q         <= 1'b1;
            SegmentDrivers <= 4'hF;
            SevenSegment   <= 8'hFF;
            test           <= 1'b0;
        end else begin
            rc             <= rc_nxt;
            idx            <= idx_nxt;
            pc             <= pc + 1'b1;
            digit_q        <= digit_nxt;
            load_q         <= 1'b0;
            SegmentDrivers <= anode_nxt;
            SevenSegment   <= cathode_nxt;
            test           <= pwm_on;
        end
    end

endmodule

// File: tb/tb_seg_display_mux.sv
// Directed bench for seg_display_mux with a short refresh slot (4 cycles).
module tb_seg_display_mux;

    logic       CLK100MHZ = 1'b0;
    logic       Reset     = 1'b1;
    logic [3:0] hours2    = 4'd0;
    logic [3:0] hours1    = 4'd0;
    logic [3:0] minutes2  = 4'd0;
    logic [3:0] minutes1  = 4'd0;
    logic [7:0] brightness = 8'd255;
    logic [3:0] SegmentDrivers;
    logic [7:0] SevenSegment;
    logic       test;

    int errors = 0;
    int checks = 0;

    seg_display_mux #(.REFRESH_DIV(4), .PWM_BITS(8)) dut (
        .CLK100MHZ      (CLK100MHZ),
        .Reset          (Reset),
        .hours2         (hours2),
        .hours1         (hours1),
        .minutes2       (minutes2),
        .minutes1       (minutes1),
        .brightness     (brightness),
        .SegmentDrivers (SegmentDrivers),
        .SevenSegment   (SevenSegment),
        .test           (test)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    task automatic tick();
        @(posedge CLK100MHZ);
        #1;
    endtask

    // Leaves the bench just after the first non-reset edge (k = 0 of the first slot).
    task automatic apply_reset();
        Reset = 1'b1;
        repeat (3) tick();
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        int k;
        apply_reset();
        brightness = 8'd255;
        repeat (6) tick();
        Reset = 1'b1;
        tick();
        checks++;
        if (SegmentDrivers !== 4'hF || SevenSegment !== 8'hFF || test !== 1'b0) begin
            errors++;
            $display("FAIL reset_first got=%h/%h/%b exp=F/FF/0", SegmentDrivers, SevenSegment, test);
        end
        tick();
        tick();
        checks++;
        if (SegmentDrivers !== 4'hF || SevenSegment !== 8'hFF || test !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold got=%h/%h/%b exp=F/FF/0", SegmentDrivers, SevenSegment, test);
        end
        Reset = 1'b0;
        tick();
        k = 0;
        while (SegmentDrivers === 4'hF && k < 10) begin
            tick();
            k++;
        end
        checks++;
        if (SegmentDrivers !== 4'b1110 || k !== 1) begin
            errors++;
            $display("FAIL reset_first_lit got=%h after %0d exp=e after 1", SegmentDrivers, k);
        end
    endtask

    // Walks k = 1..16 after release, checking anode and cathode per cycle.
    task automatic run_scan(input string name, input logic [7:0] cat0, input logic [7:0] cat1,
                            input logic [7:0] cat2, input logic [7:0] cat3);
        logic [3:0] an_tab [4];
        logic [7:0] cat_tab [4];
        logic [3:0] exp_an;
        logic [7:0] exp_cat;
        an_tab  = '{4'hE, 4'hD, 4'hB, 4'h7};
        cat_tab = '{cat0, cat1, cat2, cat3};
        for (int k = 1; k <= 16; k++) begin
            tick();
            exp_an  = ((k % 4) == 0) ? 4'hF : an_tab[(k / 4) % 4];
            exp_cat = cat_tab[(k / 4) % 4];
            checks++;
            if (SegmentDrivers !== exp_an || SevenSegment !== exp_cat) begin
                errors++;
                $display("FAIL %s k=%0d got=%h/%h exp=%h/%h", name, k, SegmentDrivers,
                         SevenSegment, exp_an, exp_cat);
            end
        end
    endtask

    task automatic test_scan();
        hours2 = 4'd1; hours1 = 4'd2; minutes2 = 4'd5; minutes1 = 4'd9;
        brightness = 8'd255;
        apply_reset();
        checks++;
        if (SegmentDrivers !== 4'hF) begin
            errors++;
            $display("FAIL scan_guard0 got=%h exp=f", SegmentDrivers);
        end
        run_scan("scan", 8'h90, 8'h92, 8'hA4, 8'hF9);
    endtask

    task automatic test_invalid_and_zero();
        logic [7:0] exp_h2;
`ifdef SEG_LEADING_BLANK_EN
        exp_h2 = 8'hFF;
`else
        exp_h2 = 8'hC0;
`endif
        hours2 = 4'd0; hours1 = 4'd7; minutes2 = 4'd12; minutes1 = 4'd0;
        brightness = 8'd255;
        apply_reset();
        run_scan("bcd_edge", 8'hC0, 8'hBF, 8'hF8, exp_h2);
    endtask

    task automatic test_pwm_off();
        int bad;
        hours2 = 4'd8; hours1 = 4'd8; minutes2 = 4'd8; minutes1 = 4'd8;
        brightness = 8'd0;
        apply_reset();
        bad = 0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (SegmentDrivers !== 4'hF || test !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL pwm_off bad_cycles=%0d exp=0", bad);
        end
    endtask

    task automatic count_test(input string name, input logic [7:0] b, input int exp_cnt);
        int cnt;
        int multi;
        brightness = b;
        repeat (3) tick();
        cnt = 0;
        multi = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            if (test === 1'b1) cnt++;
            if (SegmentDrivers !== 4'hF && $countones(~SegmentDrivers) != 1) multi++;
        end
        checks++;
        if (cnt !== exp_cnt || multi !== 0) begin
            errors++;
            $display("FAIL %s lit=%0d multi=%0d exp lit=%0d multi=0", name, cnt, multi, exp_cnt);
        end
    endtask

    task automatic test_pwm_duty();
        apply_reset();
        count_test("pwm_half", 8'd128, 128);
        count_test("pwm_full", 8'd255, 255);
        count_test("pwm_one", 8'd1, 1);
    endtask

    task automatic test_midslot_change();
        hours2 = 4'd1; hours1 = 4'd2; minutes2 = 4'd5; minutes1 = 4'd3;
        brightness = 8'd255;
        apply_reset();
        tick();
        minutes1 = 4'd4;
        for (int k = 2; k <= 3; k++) begin
            tick();
            checks++;
            if (SegmentDrivers !== 4'hE || SevenSegment !== 8'hB0) begin
                errors++;
                $display("FAIL midslot_hold k=%0d got=%h/%h exp=e/b0", k, SegmentDrivers, SevenSegment);
            end
        end
        repeat (14) tick();
        checks++;
        if (SegmentDrivers !== 4'hE || SevenSegment !== 8'h99) begin
            errors++;
            $display("FAIL midslot_next got=%h/%h exp=e/99", SegmentDrivers, SevenSegment);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_invalid_and_zero();
        test_pwm_off();
        test_pwm_duty();
        test_midslot_change();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
